// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, fixed-latency imem request, 2-entry return queue,
// valid/ready output handshake and redirect flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] machinecode,
    output logic [31:0] pc_out,
    output logic        valid,
    input  logic        ready
);

    typedef enum logic {
        ST_RST = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_addr;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_q_word [2];
    logic [31:0] r_q_addr [2];
    logic [31:0] r_last_word;
    logic [31:0] r_last_addr;

    logic        w_run;
    logic        w_redirect;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_occupancy;
    logic [1:0]  w_entry_we;
    logic [31:0] w_head_word;
    logic [31:0] w_head_addr;
    logic        w_unused;

    assign w_unused = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue only when the word would still have a queue slot on return,
    // counting the slot freed by a pop happening this same cycle.
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        w_redirect   = 1'b0;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_issue      = 1'b0;
        w_occupancy  = 3'd0;
        case (r_state)
            ST_RST: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_run        = 1'b1;
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RST;
            end
        endcase
        w_redirect  = w_run && redirect;
        w_pop       = valid && ready;
        w_push      = r_inflight && !w_redirect;
        w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue     = w_run && !w_redirect && (w_occupancy < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_addr <= 32'h0;
            r_count         <= 2'd0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc            <= r_pc + 32'd4;
                r_inflight_addr <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry_we
            assign w_entry_we[gi] = w_push && (r_wr_ptr == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_entry_we[i]) begin
                r_q_word[i] <= imem_rdata;
                r_q_addr[i] <= r_inflight_addr;
            end
        end
    end

    // Remember the last presented head so the outputs hold while the queue is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_word <= 32'h0;
            r_last_addr <= 32'h0;
        end else if (valid) begin
            r_last_word <= w_head_word;
            r_last_addr <= w_head_addr;
        end
    end

    assign w_head_word = r_q_word[r_rd_ptr];
    assign w_head_addr = r_q_addr[r_rd_ptr];

    assign valid       = (r_count != 2'd0);
    assign machinecode = valid ? w_head_word : r_last_word;
    assign pc_out      = valid ? w_head_addr : r_last_addr;
    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboard of accepted words plus per-cycle
// checks of request, latency, backpressure, redirect and reset behaviour.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] machinecode;
    logic [31:0] pc_out;
    logic        valid;
    logic        ready;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .machinecode(machinecode),
        .pc_out     (pc_out),
        .valid      (valid),
        .ready      (ready)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h2000_0000 + {2'b00, a[31:2]};
    endfunction

    // Single-cycle latency instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.word = rom(pc);
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted word must be the next one the stimulus expected.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc 0x%08h word 0x%08h, required no word", pc_out, machinecode);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] accept pc=0x%08h word=0x%08h", pc_out, machinecode);
                chk("sb_word", machinecode, e.word);
                chk("sb_pc", pc_out, e.pc);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic rdr, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        ready       = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
    endtask

    // Reset for two edges, check the cleared outputs, then release. The caller's
    // next cyc() crosses the edge into RUN, so it lands in C0.
    task automatic do_reset(input logic rdr_in_rst);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        ready    = 1'b0;
        redirect = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_mc", machinecode, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        redirect    = rdr_in_rst;
        redirect_pc = 32'h0000_0100;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Streaming
        do_reset(1'b0);
        expect_word(32'h0); expect_word(32'h4); expect_word(32'h8);
        cyc(1, 0, 0);
        chk("c0_req", 32'(imem_req), 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", 32'(valid), 32'h0);
        cyc(1, 0, 0);
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", 32'(valid), 32'h0);
        cyc(1, 0, 0);
        chk("c2_valid", 32'(valid), 32'h1);
        chk("c2_mc", machinecode, 32'h2000_0000);
        chk("c2_pc", pc_out, 32'h0);
        cyc(1, 0, 0);
        chk("c3_pc", pc_out, 32'h4);
        cyc(1, 0, 0);
        chk("c4_pc", pc_out, 32'h8);
        chk("c4_mc", machinecode, 32'h2000_0002);

        // Backpressure, then redirect with two words buffered
        do_reset(1'b0);
        expect_word(32'h0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("bp_c2_valid", 32'(valid), 32'h1);
        chk("bp_c2_req", 32'(imem_req), 32'h0);
        cyc(0, 0, 0);
        chk("bp_full_req", 32'(imem_req), 32'h0);
        chk("bp_head_pc", pc_out, 32'h0);
        chk("bp_head_mc", machinecode, 32'h2000_0000);
        cyc(1, 0, 0);
        chk("bp_pop_req", 32'(imem_req), 32'h1);
        chk("bp_pop_addr", imem_addr, 32'h8);
        cyc(0, 0, 0);
        chk("bp_next_pc", pc_out, 32'h4);
        chk("bp_next_req", 32'(imem_req), 32'h0);
        expect_word(32'h40); expect_word(32'h44); expect_word(32'h48);
        expect_word(32'hFFFF_FFFC); expect_word(32'h0); expect_word(32'h4);
        cyc(0, 1, 32'h0000_0043);
        chk("rd_req_blocked", 32'(imem_req), 32'h0);
        cyc(1, 0, 0);
        chk("rd1_valid", 32'(valid), 32'h0);
        chk("rd1_addr", imem_addr, 32'h40);
        cyc(1, 0, 0);
        chk("rd2_valid", 32'(valid), 32'h0);
        cyc(1, 0, 0);
        chk("rd3_pc", pc_out, 32'h40);
        chk("rd3_mc", machinecode, 32'h2000_0010);
        cyc(1, 0, 0);

        // Redirect with simultaneous pop and a word in flight; wrap at 2^32
        cyc(1, 1, 32'hFFFF_FFFC);
        chk("rp_head_pc", pc_out, 32'h48);
        chk("rp_req", 32'(imem_req), 32'h0);
        cyc(1, 0, 0);
        chk("wr1_valid", 32'(valid), 32'h0);
        chk("wr1_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 0);
        chk("wr2_valid", 32'(valid), 32'h0);
        chk("wr2_addr", imem_addr, 32'h0);
        cyc(1, 0, 0);
        chk("wr3_pc", pc_out, 32'hFFFF_FFFC);
        chk("wr3_mc", machinecode, 32'h5FFF_FFFF);
        cyc(1, 0, 0);
        chk("wr4_pc", pc_out, 32'h0);
        cyc(1, 0, 0);
        chk("wr5_pc", pc_out, 32'h4);

        // Reset mid-stream; redirect during RST must be ignored
        do_reset(1'b1);
        expect_word(32'h0); expect_word(32'h4);
        cyc(1, 0, 0);
        chk("mr_c0_addr", imem_addr, 32'h0);
        chk("mr_c0_req", 32'(imem_req), 32'h1);
        cyc(1, 0, 0);
        chk("mr_c1_valid", 32'(valid), 32'h0);
        cyc(1, 0, 0);
        chk("mr_c2_pc", pc_out, 32'h0);
        chk("mr_c2_mc", machinecode, 32'h2000_0000);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("mr_hold_valid", 32'(valid), 32'h1);
        chk("mr_hold_pc", pc_out, 32'h8);
        cyc(0, 0, 0);
        chk("mr_hold2_pc", pc_out, 32'h8);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
